// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiply, restoring divide, sign fix-up.
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle 33x33 multiplier.
module muldiv_seq #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned CNT_BITS = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e              r_state, w_state_d;
  logic [XLEN-1:0]     r_hi, r_lo, r_mcand, r_result;
  logic [CNT_BITS-1:0] r_cnt;
  logic [2:0]          r_func3;
  logic                r_s1, r_s2;

  logic            w_is_div, w_sgn1, w_sgn2, w_s1, w_s2;
  logic            w_div0, w_ovf, w_special, w_accept, w_fast;
  logic [XLEN-1:0] w_mag1, w_mag2, w_special_res, w_fast_res;

  assign w_is_div = func3_i[2];
  // Operand signedness: MULHSU treats rs2 as unsigned, U-variants treat both as unsigned
  assign w_sgn1   = w_is_div ? ~func3_i[0] : (func3_i[1:0] != 2'b11);
  assign w_sgn2   = w_is_div ? ~func3_i[0] : ~func3_i[1];
  assign w_s1     = w_sgn1 & rs1_i[XLEN-1];
  assign w_s2     = w_sgn2 & rs2_i[XLEN-1];
  assign w_mag1   = w_s1 ? (~rs1_i + 1'b1) : rs1_i;
  assign w_mag2   = w_s2 ? (~rs2_i + 1'b1) : rs2_i;

  assign w_div0 = w_is_div & (rs2_i == '0);
  assign w_ovf  = w_is_div & ~func3_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
  assign w_special = w_div0 | w_ovf;
  always_comb begin
    w_special_res = '0;
    if (w_div0)          w_special_res = func3_i[1] ? rs1_i : '1;
    else if (!func3_i[1]) w_special_res = rs1_i;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] w_fprod;
  logic                     w_unused_fprod;
  assign w_fprod = $signed({w_s1, rs1_i}) * $signed({w_s2, rs2_i});
  assign w_unused_fprod = ^w_fprod[2*XLEN+1:2*XLEN];
  assign w_fast     = ~w_is_div;
  assign w_fast_res = (func3_i[1:0] == 2'b00) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`else
  assign w_fast     = 1'b0;
  assign w_fast_res = '0;
`endif

  assign w_accept = (r_state == StIdle) & start_i & ~flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    if (flush_i) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle:  if (start_i) w_state_d = (w_special | w_fast) ? StDone : StCalc;
        StCalc:  if (r_cnt == CNT_BITS'(XLEN-1)) w_state_d = StFix;
        StFix:   w_state_d = StDone;
        StDone:  if (!hold_i) w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  assign stall_o  = ~flush_i & (w_accept | (r_state == StCalc) | (r_state == StFix) |
                                ((r_state == StDone) & hold_i));
  assign done_o   = (r_state == StDone);
  assign result_o = r_result;

  // Iteration datapath: r_hi is the product high half / partial remainder
  logic [XLEN:0]     w_sum, w_rem_sh, w_diff;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;

  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_mcand};

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = (r_s1 ^ r_s2) ? (~w_prod + 1'b1) : w_prod;
  assign w_quo      = (r_s1 ^ r_s2) ? (~r_lo + 1'b1) : r_lo;
  assign w_rem      = r_s1 ? (~r_hi + 1'b1) : r_hi;

  always_comb begin
    w_fix_res = '0;
    case (r_func3)
      3'b000:                 w_fix_res = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = w_quo;
      default:                w_fix_res = w_rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_mcand  <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_func3  <= '0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
    end else if (!flush_i) begin
      if (w_accept) begin
        r_hi    <= '0;
        r_lo    <= w_is_div ? w_mag1 : w_mag2;
        r_mcand <= w_is_div ? w_mag2 : w_mag1;
        r_cnt   <= '0;
        r_func3 <= func3_i;
        r_s1    <= w_s1;
        r_s2    <= w_s2;
        if (w_special)   r_result <= w_special_res;
        else if (w_fast) r_result <= w_fast_res;
      end else if (r_state == StCalc) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_func3[2]) begin
          // w_diff[XLEN] is the borrow: restore on borrow, quotient bit enters at LSB
          r_hi <= w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], ~w_diff[XLEN]};
        end else begin
          r_hi <= w_sum[XLEN:1];
          r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
        end
      end else if (r_state == StFix) begin
        r_result <= w_fix_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: driver pushes model results, a forked monitor checks done_o.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start_i, flush_i, hold_i;
  logic [2:0]  func3_i;
  logic [31:0] rs1_i, rs2_i;
  logic        stall_o, done_o;
  logic [31:0] result_o;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_res;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  muldiv_seq #(.XLEN(32), .CNT_BITS(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .hold_i   (hold_i),
    .func3_i  (func3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Architectural result computed with plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (f)
      3'd0, 3'd1: p = sa * sb;
      3'd2:       p = sa * ub;
      3'd3:       p = ua * ub;
      3'd4:       if (b == 0) p = '1; else p = sa / sb;
      3'd5:       if (b == 0) p = '1; else p = ua / ub;
      3'd6:       if (b == 0) p = sa; else p = sa % sb;
      default:    if (b == 0) p = ua; else p = ua % ub;
    endcase
    return (f == 3'd0 || f[2]) ? p[31:0] : p[63:32];
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 34;
  endfunction

  task automatic monitor();
    logic prev = 1'b0;
    logic have = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (done_o === 1'b1) begin
        if (!prev) begin
          if (exp_q.size() == 0) begin
            have = 1'b0;
            chk("unexpected_done", {31'b0, done_o}, 32'd0);
          end else begin
            have = 1'b1;
            e = exp_q.pop_front();
            chk("done_cycle", cyc, e.cyc);
          end
        end
        if (have) chk("result", result_o, e.res);
      end
      prev = (done_o === 1'b1);
    end
  endtask

  task automatic op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input int hold_n);
    int lat;
    exp_t e;
    lat = latency(f, a, b);
    @(negedge clk);
    start_i = 1'b1; func3_i = f; rs1_i = a; rs2_i = b; hold_i = 1'b0;
    e.res = model(f, a, b);
    e.cyc = cyc + lat;
    exp_q.push_back(e);
    #1 chk("stall_accept", {31'b0, stall_o}, 32'd1);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk); #1;
      chk("stall_busy", {30'b0, stall_o, done_o}, 32'd2);
    end
    for (int h = 0; h < hold_n; h++) begin
      @(negedge clk); hold_i = 1'b1; #1;
      chk("stall_hold", {30'b0, stall_o, done_o}, 32'd3);
    end
    @(negedge clk); hold_i = 1'b0; #1;
    chk("capture", {30'b0, stall_o, done_o}, 32'd1);
    @(negedge clk); start_i = 1'b0; #1;
    chk("idle_after", {30'b0, stall_o, done_o}, 32'd0);
    last_res = e.res;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    func3_i = '0; rs1_i = '0; rs2_i = '0; last_res = '0;
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);
    #1;
    chk("reset_flags", {30'b0, stall_o, done_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    @(negedge clk); rst = 1'b0;

    op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    op(3'd5, 32'd100, 32'd7, 0);
    op(3'd7, 32'd100, 32'd7, 0);
    op(3'd5, 32'd5, 32'd0, 0);
    op(3'd7, 32'd5, 32'd0, 0);
    op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Flush mid-divide: no done, result held, then a fresh DIVU
    @(negedge clk);
    start_i = 1'b1; func3_i = 3'd4; rs1_i = 32'd100; rs2_i = 32'd7;
    repeat (10) @(negedge clk);
    flush_i = 1'b1; start_i = 1'b0; #1;
    chk("stall_flush", {31'b0, stall_o}, 32'd0);
    @(negedge clk); flush_i = 1'b0; #1;
    chk("after_flush", {30'b0, stall_o, done_o}, 32'd0);
    chk("flush_result_held", result_o, last_res);
    op(3'd5, 32'd9, 32'd3, 0);

    op(3'd4, 32'd20, 32'd3, 3);

    // Asynchronous reset while iterating
    @(negedge clk);
    start_i = 1'b1; func3_i = 3'd0; rs1_i = 32'd12345; rs2_i = 32'd678;
    repeat (5) @(negedge clk);
    start_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_flags", {30'b0, stall_o, done_o}, 32'd0);
    chk("rst_mid_result", result_o, 32'd0);
    @(negedge clk); rst = 1'b0;
    last_res = '0;

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      op(f, a, b, $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide instructions, attached beside the execute-stage ALU. It accepts the forwarded operands and `func3` of an M-extension instruction held in ID/EX. It stalls the EX/MEM register (gating `exemem_en`) while it iterates, then presents a 32-bit result for one capture cycle. It owns the shift/add/subtract datapath, the iteration counter, sign correction and the RISC-V special cases.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.
- `CNT_BITS`, 6, iteration counter width.

Ports:
- `clk`  in  1  — clock.
- `rst`  in  1  — asynchronous, active-high reset.
- `start_i`  in  1  — ID/EX holds a valid M-ext instruction; level, held until the instruction leaves EX.
- `flush_i`  in  1  — abort the current operation (branch/trap flush).
- `hold_i`  in  1  — downstream stall (EX/MEM not accepting); extends DONE.
- `func3_i`  in  3  — 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_i`, `rs2_i`  in  32  — forwarded operands, sampled only on the accepting cycle.
- `stall_o`  out  1  — high means the EX/MEM register must not capture.
- `done_o`  out  1  — `result_o` is valid this cycle.
- `result_o`  out  32  — result, held until the next accept.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE:**
  - On `start_i & ~flush_i`, latch operands (magnitudes), sign flags and `func3`, and clear the counter.
  - Divide-by-zero and signed overflow go directly to DONE.
  - Otherwise go to CALC.
- **CALC:** one radix-2 step per cycle, 32 steps; the counter counts 0..31, then go to FIX.
  - Multiply: shift-add on unsigned magnitudes into a 64-bit accumulator.
  - Divide: restoring, 33-bit partial remainder, quotient shifted in LSB-first.
- **FIX:** apply sign correction and select the result, then go to DONE.
  - MUL takes product[31:0]; MULH/MULHSU/MULHU take product[63:32].
  - Multiply product sign = sign1 XOR sign2, with sign2 forced to 0 for MULHSU and both signs forced to 0 for MULHU.
  - Quotient sign = sign1 XOR sign2.
  - Remainder takes the dividend's sign.
- **DONE:** `done_o` = 1.
  - If `hold_i`, stay in DONE.
  - Otherwise return to IDLE. `start_i` is ignored in DONE, so the same instruction is not restarted.
- Special cases (no iteration):
  - DIV/DIVU by zero → quotient 0xFFFFFFFF; REM/REMU by zero → rs1.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; the matching REM → 0.
- **Flush:** `flush_i` in any state forces IDLE on the next edge, with no `done_o` and `result_o` unchanged. `flush_i` has priority over `start_i` and `hold_i`.
- Signed negation uses two's complement. The most-negative input is handled as an unsigned 32-bit magnitude of 0x80000000.

## Timing
- Reset values: state IDLE, counter 0, `result_o` 0, `done_o` 0, `stall_o` 0; internal accumulators 0.
- `stall_o` = `(IDLE & start_i & ~flush_i) | CALC | FIX | (DONE & hold_i)`.
  - It is combinational in the accepting cycle, so EX/MEM does not capture the unfinished instruction.
  - It is forced to 0 while `flush_i` is high.
- `done_o` and `result_o` are registered outputs. `done_o` = 1 exactly in DONE cycles.
- Latency, with accept at cycle T:
  - Iterative path: CALC T+1..T+32, FIX T+33, DONE T+34, so `done_o` is first high in T+34. `stall_o` is high T..T+33.
  - Special case: DONE at T+1; `stall_o` is high in T only.
- Back-to-back: a new `start_i` is accepted in the IDLE cycle following DONE, so accepts are at least 2 cycles apart.
- Reset asserted mid-CALC: immediate return to reset values; no `done_o`.

## Configuration
- `MULDIV_FAST_MUL_EN`:
  - **Defined:** MUL/MULH/MULHSU/MULHU use a single-cycle 33×33 signed multiplier. The product is registered on the accepting cycle, the FSM goes IDLE → DONE, `done_o` is high at T+1, and `stall_o` is high in T only. Divide timing is unchanged.
  - **Undefined:** all multiplies use the 32-step iterative path with the same latency as divide (T+34).

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `result_o` 0xFFFFFFEB. `done_o` at T+34, or at T+1 with `MULDIV_FAST_MUL_EN`. `stall_o` drops exactly in the `done_o` cycle.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU of the same operands → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIVU 100 / 7 → 14; REMU → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0. Each completes with `done_o` at T+1.
- DIV started at T, `flush_i` pulsed at T+10 → IDLE at T+11, no `done_o`, `result_o` unchanged. A new DIVU 9 / 3 at T+12 returns 3 at T+46.
- DIV 20 / 3 with `hold_i` = 1 for 3 cycles after reaching DONE → `done_o` and `stall_o` high for those 3 cycles with `result_o` = 6 stable. Then `stall_o` = 0 for one capture cycle, and no restart while `start_i` stays high in DONE.
